// File: rtl/gps_corr_pkg.sv
// rtl/gps_corr_pkg.sv - shared constants and helpers for the P-code correlator datapath
package gps_corr_pkg;

  localparam int SAMPLE_WIDTH_DEF    = 8;
  localparam int ACC_WIDTH_DEF       = 24;
  localparam int CNT_WIDTH_DEF       = 16;
  localparam int INT_LEN_DEFAULT_DEF = 10230;

  function automatic logic signed [63:0] acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

  // Chip 0 correlates as +1, chip 1 as -1.
  function automatic logic signed [1:0] chip_sign(input logic chip);
    return chip ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/gps_sat_acc.sv
// rtl/gps_sat_acc.sv - one saturating despread accumulator with clear, add-enable and dump capture
module gps_sat_acc
  import gps_corr_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_add,
  input  logic                    i_dump,
  input  logic                    i_chip,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  output logic [ACC_WIDTH-1:0]    o_dump_val,
  output logic                    o_dump_sat
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_sat;
  logic signed [1:0]            w_sign;
  logic signed [SAMPLE_WIDTH:0] w_sx;
  logic signed [SAMPLE_WIDTH:0] w_contrib;
  logic signed [ACC_WIDTH:0]    w_sum;
  logic                         w_ovf;
  logic signed [ACC_WIDTH-1:0]  w_next;

  assign w_sign    = chip_sign(i_chip);
  assign w_sx      = {i_sample[SAMPLE_WIDTH-1], i_sample};
  assign w_contrib = w_sign[1] ? -w_sx : w_sx;
  assign w_sum     = {r_acc[ACC_WIDTH-1], r_acc}
                   + {{(ACC_WIDTH-SAMPLE_WIDTH){w_contrib[SAMPLE_WIDTH]}}, w_contrib};

  // The extended sum left the ACC_WIDTH range exactly when its top two bits disagree.
  assign w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_next = !w_ovf ? w_sum[ACC_WIDTH-1:0] : (w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_sat      <= 1'b0;
      o_dump_val <= '0;
      o_dump_sat <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (i_add) begin
      if (i_dump) begin
        o_dump_val <= w_next;
        o_dump_sat <= r_sat | w_ovf;
        r_acc      <= '0;
        r_sat      <= 1'b0;
      end else begin
        r_acc <= w_next;
        r_sat <= r_sat | w_ovf;
      end
    end
  end

endmodule

// File: rtl/pcode_despread_acc.sv
// rtl/pcode_despread_acc.sv - P-code despreader/integrator with dump handshake; PCODE_EARLY_LATE_EN adds early/late arms
module pcode_despread_acc
  import gps_corr_pkg::*;
#(
  parameter int SAMPLE_WIDTH    = SAMPLE_WIDTH_DEF,
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int INT_LEN_DEFAULT = INT_LEN_DEFAULT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restart,
  input  logic [CNT_WIDTH-1:0]    int_len,
  input  logic                    chip_en,
  input  logic                    chip,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_prompt,
`ifdef PCODE_EARLY_LATE_EN
  output logic [ACC_WIDTH-1:0]    out_early,
  output logic [ACC_WIDTH-1:0]    out_late,
`endif
  output logic                    out_sat,
  output logic                    overrun
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_start;
  logic                 r_valid;
  logic                 r_overrun;
  logic [CNT_WIDTH-1:0] w_len;
  logic                 w_last;

  // r_start marks the first cycle of an epoch, where int_len is taken live and latched.
  assign w_len  = !r_start ? r_len : ((int_len == '0) ? CNT_WIDTH'(1) : int_len);
  assign w_last = chip_en && !restart && (r_cnt == w_len - CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_len     <= CNT_WIDTH'(INT_LEN_DEFAULT);
      r_start   <= 1'b1;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_len   <= w_len;
      r_start <= restart || w_last;
      if (restart || w_last) begin
        r_cnt <= '0;
      end else if (chip_en) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_last) begin
        r_valid <= 1'b1;
        if (r_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign overrun   = r_overrun;

`ifdef PCODE_EARLY_LATE_EN
  logic r_chip_d1;
  logic r_chip_d2;
  logic w_sat_e;
  logic w_sat_p;
  logic w_sat_l;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_chip_d1 <= 1'b0;
      r_chip_d2 <= 1'b0;
    end else if (chip_en) begin
      r_chip_d1 <= chip;
      r_chip_d2 <= r_chip_d1;
    end
  end

  gps_sat_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_early (
    .clk(clk), .rst(rst), .i_clr(restart), .i_add(chip_en), .i_dump(w_last),
    .i_chip(chip), .i_sample(sample), .o_dump_val(out_early), .o_dump_sat(w_sat_e)
  );
  gps_sat_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_prompt (
    .clk(clk), .rst(rst), .i_clr(restart), .i_add(chip_en), .i_dump(w_last),
    .i_chip(r_chip_d1), .i_sample(sample), .o_dump_val(out_prompt), .o_dump_sat(w_sat_p)
  );
  gps_sat_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_late (
    .clk(clk), .rst(rst), .i_clr(restart), .i_add(chip_en), .i_dump(w_last),
    .i_chip(r_chip_d2), .i_sample(sample), .o_dump_val(out_late), .o_dump_sat(w_sat_l)
  );

  assign out_sat = w_sat_e | w_sat_p | w_sat_l;
`else
  gps_sat_acc #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_prompt (
    .clk(clk), .rst(rst), .i_clr(restart), .i_add(chip_en), .i_dump(w_last),
    .i_chip(chip), .i_sample(sample), .o_dump_val(out_prompt), .o_dump_sat(out_sat)
  );
`endif

endmodule
